// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator call dispatcher.
// The floor count is fixed here so that every file sees the same floor_t width.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

  typedef logic [FLOOR_W-1:0]    floor_t;
  typedef logic [FLOOR_W:0]      floor_ext_t;
  typedef logic [NUM_FLOORS-1:0] floor_mask_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    TRAVEL = 3'd2,
    DWELL  = 3'd3,
    FAULT  = 3'd4
  } disp_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/elevator_next_floor_sel.sv
// SCAN-order target picker: keep sweeping in the current direction while calls remain
// ahead, otherwise reverse. A call only at the current floor selects that floor.
module elevator_next_floor_sel
  import elevator_pkg::*;
(
  input  floor_mask_t i_pending,
  input  floor_t      i_current,
  input  dir_t        i_dir,
  output floor_t      o_target,
  output dir_t        o_dir
);

  floor_ext_t cur_ext;
  logic       above_found;
  logic       below_found;
  floor_t     above_floor;
  floor_t     below_floor;

  assign cur_ext = {1'b0, i_current};

  // Scanning from the far end keeps the last hit, which is the nearest floor.
  always_comb begin
    above_found = 1'b0;
    above_floor = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (i_pending[f] && (floor_ext_t'(f) > cur_ext)) begin
        above_found = 1'b1;
        above_floor = floor_t'(f);
      end
    end
    below_found = 1'b0;
    below_floor = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (i_pending[f] && (floor_ext_t'(f) < cur_ext)) begin
        below_found = 1'b1;
        below_floor = floor_t'(f);
      end
    end
  end

  always_comb begin
    o_target = i_current;
    o_dir    = i_dir;
    if (i_dir == DIR_UP) begin
      if (above_found) begin
        o_target = above_floor;
      end else if (below_found) begin
        o_target = below_floor;
        o_dir    = DIR_DOWN;
      end
    end else begin
      if (below_found) begin
        o_target = below_floor;
      end else if (above_found) begin
        o_target = above_floor;
        o_dir    = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/elevator_call_dispatcher.sv
// Latches call buttons, picks the next floor in SCAN order, drives it to the elevator core,
// detects arrival, holds a door dwell, and faults if travel takes too long.
module elevator_call_dispatcher
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_FLOORS-1:0] i_call,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  output logic [FLOOR_W-1:0]    o_target_floor,
  output logic [NUM_FLOORS-1:0] o_call_pending,
  output logic                  o_arrived,
  output logic                  o_busy,
  output logic                  o_fault
);

  localparam int TRAVEL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DWELL_W  = $clog2(DWELL_CYCLES + 1);

  disp_state_t         state_q, state_d;
  dir_t                dir_q, dir_d;
  floor_mask_t         pending_q, pending_d;
  floor_t              target_q, target_d;
  logic                arrived_q, arrived_d;
  logic                fault_q, fault_d;
  logic [TRAVEL_W-1:0] travel_tmr_q, travel_tmr_d;
  logic [DWELL_W-1:0]  dwell_tmr_q, dwell_tmr_d;

  floor_mask_t tgt_onehot;
  floor_mask_t call_mask;
  floor_mask_t clr_mask;
  floor_t      sel_target;
  dir_t        sel_dir;
  logic        at_target;

  elevator_next_floor_sel u_sel (
    .i_pending (pending_q),
    .i_current (i_current_floor),
    .i_dir     (dir_q),
    .o_target  (sel_target),
    .o_dir     (sel_dir)
  );

  assign tgt_onehot = floor_mask_t'(1) << target_q;
  assign at_target  = ({1'b0, i_current_floor} == {1'b0, target_q});

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    target_d     = target_q;
    fault_d      = fault_q;
    travel_tmr_d = travel_tmr_q;
    dwell_tmr_d  = dwell_tmr_q;
    arrived_d    = 1'b0;
    clr_mask     = '0;
    // The door is open at the target during dwell, so that floor's button is already served.
    call_mask    = (state_q == DWELL) ? (i_call & ~tgt_onehot) : i_call;

    case (state_q)
      IDLE: begin
        if (|pending_q) state_d = SELECT;
      end
      SELECT: begin
        target_d     = sel_target;
        dir_d        = sel_dir;
        travel_tmr_d = '0;
        state_d      = TRAVEL;
      end
      TRAVEL: begin
        if (at_target) begin
          arrived_d   = 1'b1;
          clr_mask    = tgt_onehot;
          dwell_tmr_d = '0;
          state_d     = DWELL;
        end else if (travel_tmr_q == TRAVEL_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          travel_tmr_d = travel_tmr_q + TRAVEL_W'(1);
        end
      end
      DWELL: begin
        if (dwell_tmr_q == DWELL_W'(DWELL_CYCLES - 1)) begin
          if (|pending_q) state_d = SELECT;
          else            state_d = IDLE;
        end else begin
          dwell_tmr_d = dwell_tmr_q + DWELL_W'(1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pending_d = (pending_q | call_mask) & ~clr_mask;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      dir_q        <= DIR_UP;
      pending_q    <= '0;
      target_q     <= '0;
      arrived_q    <= 1'b0;
      fault_q      <= 1'b0;
      travel_tmr_q <= '0;
      dwell_tmr_q  <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      target_q     <= target_d;
      arrived_q    <= arrived_d;
      fault_q      <= fault_d;
      travel_tmr_q <= travel_tmr_d;
      dwell_tmr_q  <= dwell_tmr_d;
    end
  end

  assign o_target_floor = target_q;
  assign o_call_pending = pending_q;
  assign o_arrived      = arrived_q;
  assign o_fault        = fault_q;
  assign o_busy         = (state_q != IDLE);

endmodule
